// File: rtl/af_pkg.sv
// af_pkg: shared mode and state encodings for the activation-feedback router.
`default_nettype none

package af_pkg;

  localparam logic [1:0] AF_BYPASS = 2'd0;
  localparam logic [1:0] AF_SIG    = 2'd1;
  localparam logic [1:0] AF_TANH   = 2'd2;
  localparam logic [1:0] AF_RELU   = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_AF = 1'b1
  } af_state_t;

endpackage

`default_nettype wire

// File: rtl/af_result_fifo.sv
// af_result_fifo: power-of-two circular result buffer with occupancy count.
`default_nettype none

module af_result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/af_feedback_router.sv
// af_feedback_router: applies bypass/ReLU/sigmoid/tanh to array edge vectors
// and queues zero-padded results for the array's north input.
`default_nettype none

module af_feedback_router
  import af_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int IN_CH      = 2,
  parameter int OUT_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               af_mode,
  input  logic                     src_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_CH*WORD_W-1:0]  east_data,
  input  logic [IN_CH*WORD_W-1:0]  north_data,
  output logic [IN_CH*WORD_W-1:0]  af_operand,
  input  logic [IN_CH*WORD_W-1:0]  sig_data,
  input  logic [IN_CH*WORD_W-1:0]  tanh_data,
  input  logic                     sig_rdy,
  input  logic                     tanh_rdy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_CH*WORD_W-1:0] out_data,
  output logic                     af_timeout,
  output logic                     busy
);

  localparam int IN_W   = IN_CH * WORD_W;
  localparam int OUT_W  = OUT_CH * WORD_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WCNT_W = $clog2(AF_TIMEOUT + 1);

  af_state_t          state;
  af_state_t          state_nxt;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               push;
  logic               load_op;
  logic               timeout_hit;
  logic               sel_rdy;
  logic [IN_W-1:0]    src;
  logic [IN_W-1:0]    relu_src;
  logic [IN_W-1:0]    push_vec;
  logic [OUT_W-1:0]   push_data;

  assign src      = src_sel ? north_data : east_data;
  // Uses the pre-pop count, so a full FIFO blocks input for a cycle even on a pop.
  assign in_ready = (state == ST_IDLE) && (count != CNT_W'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign sel_rdy  = (mode_q == AF_SIG) ? sig_rdy : tanh_rdy;

  always_comb begin
    relu_src = src;
    for (int c = 0; c < IN_CH; c++) begin
      if (src[c*WORD_W + WORD_W - 1]) relu_src[c*WORD_W +: WORD_W] = '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    push_vec    = src;
    load_op     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (af_mode)
            AF_BYPASS: push = 1'b1;
            AF_RELU: begin
              push     = 1'b1;
              push_vec = relu_src;
            end
            default: begin
              load_op   = 1'b1;
              state_nxt = ST_WAIT_AF;
            end
          endcase
        end
      end
      ST_WAIT_AF: begin
        // The first waiting cycle ignores rdy so a flag left over from a
        // previous operand is never mistaken for this result.
        if ((wait_cnt != '0) && sel_rdy) begin
          push      = 1'b1;
          push_vec  = (mode_q == AF_SIG) ? sig_data : tanh_data;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == WCNT_W'(AF_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    push_data = '0;
    push_data[OUT_W-1 -: IN_W] = push_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      mode_q     <= AF_BYPASS;
      af_operand <= '0;
      af_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_op) begin
        wait_cnt   <= '0;
        mode_q     <= af_mode;
        af_operand <= src;
      end else if (state == ST_WAIT_AF) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end
      if (timeout_hit) af_timeout <= 1'b1;
    end
  end

  af_result_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (out_data),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign busy      = (state != ST_IDLE) || out_valid;

endmodule

`default_nettype wire

// File: tb/tb_af_feedback_router.sv
// tb_af_feedback_router: directed and randomized checks against a queue-based model.
`default_nettype none

module tb_af_feedback_router;

  localparam int WORD_W = 32;
  localparam int IN_CH  = 2;
  localparam int OUT_CH = 4;
  localparam int DEPTH  = 4;
  localparam int TMO    = 64;
  localparam int IN_W   = IN_CH * WORD_W;
  localparam int OUT_W  = OUT_CH * WORD_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       af_mode;
  logic             src_sel;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  east_data;
  logic [IN_W-1:0]  north_data;
  logic [IN_W-1:0]  af_operand;
  logic [IN_W-1:0]  sig_data;
  logic [IN_W-1:0]  tanh_data;
  logic             sig_rdy;
  logic             tanh_rdy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             af_timeout;
  logic             busy;

  always #5 clk = ~clk;

  af_feedback_router #(
    .WORD_W     (WORD_W),
    .IN_CH      (IN_CH),
    .OUT_CH     (OUT_CH),
    .FIFO_DEPTH (DEPTH),
    .AF_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .af_mode    (af_mode),
    .src_sel    (src_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .east_data  (east_data),
    .north_data (north_data),
    .af_operand (af_operand),
    .sig_data   (sig_data),
    .tanh_data  (tanh_data),
    .sig_rdy    (sig_rdy),
    .tanh_rdy   (tanh_rdy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .af_timeout (af_timeout),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: result queue plus a "waiting on activation" flag and elapsed-cycle count.
  logic [OUT_W-1:0] m_q[$];
  bit               m_wait;
  int               m_cnt;
  logic [1:0]       m_mode;
  logic [IN_W-1:0]  m_op;
  bit               m_to;

  task automatic check_val(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [OUT_W-1:0] pad(input logic [IN_W-1:0] v);
    return {v, {(OUT_W-IN_W){1'b0}}};
  endfunction

  function automatic logic [IN_W-1:0] relu(input logic [IN_W-1:0] v);
    logic [IN_W-1:0] r = v;
    for (int c = 0; c < IN_CH; c++)
      if (v[c*WORD_W + WORD_W - 1]) r[c*WORD_W +: WORD_W] = '0;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_wait = 0;
    m_cnt  = 0;
    m_mode = 2'd0;
    m_op   = '0;
    m_to   = 0;
  endtask

  task automatic model_edge();
    bit               do_pop;
    bit               do_push;
    logic [OUT_W-1:0] pv;
    logic [IN_W-1:0]  s;
    logic [OUT_W-1:0] tmp;
    do_pop  = (m_q.size() > 0) && out_ready;
    do_push = 0;
    pv      = '0;
    s       = src_sel ? north_data : east_data;
    if (!m_wait) begin
      if (in_valid && m_q.size() < DEPTH) begin
        if (af_mode == 2'd0) begin
          do_push = 1; pv = pad(s);
        end else if (af_mode == 2'd3) begin
          do_push = 1; pv = pad(relu(s));
        end else begin
          m_wait = 1; m_cnt = 0; m_mode = af_mode; m_op = s;
        end
      end
    end else begin
      if (m_cnt >= 1 && ((m_mode == 2'd1) ? sig_rdy : tanh_rdy)) begin
        do_push = 1;
        pv      = pad((m_mode == 2'd1) ? sig_data : tanh_data);
        m_wait  = 0;
      end else if (m_cnt + 1 == TMO) begin
        m_to   = 1;
        m_wait = 0;
      end else begin
        m_cnt++;
      end
    end
    if (do_pop) tmp = m_q.pop_front();
    if (do_push) m_q.push_back(pv);
  endtask

  task automatic check_outputs();
    check_val("in_ready",   in_ready,   !m_wait && (m_q.size() < DEPTH));
    check_val("out_valid",  out_valid,  m_q.size() > 0);
    check_val("out_data",   out_data,   (m_q.size() > 0) ? m_q[0] : '0);
    check_val("busy",       busy,       m_wait || (m_q.size() > 0));
    check_val("af_timeout", af_timeout, m_to);
    check_val("af_operand", af_operand, m_op);
  endtask

  // Called at a falling edge with inputs already set.
  task automatic step();
    check_outputs();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
  endtask

  function automatic logic [IN_W-1:0] rnd_vec();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b0; af_mode = 2'd0; src_sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    east_data = '0; north_data = '0; sig_data = '0; tanh_data = '0; sig_rdy = 1'b0; tanh_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // Bypass with padding
    east_data = {32'h5, 32'hFFFF_FFFE}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("bypass_pad", out_data, {32'h5, 32'hFFFF_FFFE, 64'h0});
    out_ready = 1'b1;
    step();

    // ReLU back-to-back
    af_mode = 2'd3; in_valid = 1'b1;
    east_data = {32'h8000_0001, 32'h7FFF_FFFF};
    step();
    check_val("relu_0", out_data, {32'h0, 32'h7FFF_FFFF, 64'h0});
    east_data = {32'h0000_1234, 32'hFFFF_0000};
    step();
    check_val("relu_1", out_data, {32'h0000_1234, 32'h0, 64'h0});
    in_valid = 1'b0;
    step();

    // Sigmoid with rdy already high: push at t+2, not t+1
    out_ready = 1'b0; af_mode = 2'd1; sig_rdy = 1'b1; sig_data = rnd_vec();
    east_data = rnd_vec(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_val("sig_not_t1", out_valid, 1'b0);
    step();
    check_val("sig_at_t2", out_data, pad(sig_data));
    sig_rdy = 1'b0; out_ready = 1'b1;
    step();

    // Tanh sourced from north edge
    out_ready = 1'b0; af_mode = 2'd2; src_sel = 1'b1; north_data = rnd_vec();
    tanh_data = rnd_vec(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("tanh_operand", af_operand, north_data);
    repeat (2) step();
    tanh_rdy = 1'b1;
    step();
    tanh_rdy = 1'b0; out_ready = 1'b1; src_sel = 1'b0;
    step();

    // Full FIFO blocks input for a cycle even with a pop
    out_ready = 1'b0; af_mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      east_data = rnd_vec();
      step();
    end
    check_val("full_blocks", in_ready, 1'b0);
    east_data = rnd_vec(); out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();

    // Sigmoid timeout
    af_mode = 2'd1; sig_rdy = 1'b0; in_valid = 1'b1; east_data = rnd_vec();
    step();
    in_valid = 1'b0;
    repeat (TMO) step();
    check_val("timeout_set", af_timeout, 1'b1);
    af_mode = 2'd0; in_valid = 1'b1; east_data = rnd_vec();
    step();
    in_valid = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      af_mode    = 2'($urandom_range(0, 3));
      src_sel    = 1'($urandom_range(0, 1));
      in_valid   = ($urandom_range(0, 9) < 6);
      out_ready  = ($urandom_range(0, 9) < 6);
      east_data  = rnd_vec();
      north_data = rnd_vec();
      sig_data   = rnd_vec();
      tanh_data  = rnd_vec();
      sig_rdy    = ((i / 200) % 3 != 2) && ($urandom_range(0, 3) == 0);
      tanh_rdy   = ((i / 200) % 3 != 2) && ($urandom_range(0, 3) == 0);
      step();
    end

    // Asynchronous reset while waiting with two queued results
    in_valid = 1'b0; out_ready = 1'b0; sig_rdy = 1'b0; tanh_rdy = 1'b0;
    repeat (TMO + 2) step();
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    out_ready = 1'b0; af_mode = 2'd0; in_valid = 1'b1;
    repeat (2) begin
      east_data = rnd_vec();
      step();
    end
    af_mode = 2'd1; east_data = rnd_vec();
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check_val("pre_rst_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_timeout", af_timeout, 1'b0);
    check_val("rst_out_data", out_data, '0);
    check_val("rst_operand", af_operand, '0);
    @(negedge clk);
    reset = 1'b1;
    check_val("post_rst_ready", in_ready, 1'b1);
    af_mode = 2'd0; in_valid = 1'b1; east_data = rnd_vec();
    step();
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
